// File: rtl/lvds_host.sv
// Host-end LVDS link engine: frames 66-bit words into a 4-bit-per-clock nibble
// stream and deframes the recovered nibble stream, all in the 200 MHz word clock.
module lvds_host #(
   parameter bit TINV = 1'b0,
   parameter bit RINV = 1'b0
) (
   input  logic        c,
   input  logic        r,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [65:0] tx_data,
   output logic [3:0]  txd,
   input  logic [3:0]  rxd,
   output logic        link_up,
   output logic        rx_valid,
   output logic [65:0] rx_data,
   output logic [15:0] rx_count
);

   localparam logic [3:0] TX_MASK = {4{TINV}};
   localparam logic [3:0] TX_IDLE = 4'hF ^ TX_MASK;

   typedef enum logic [1:0] {RX_DOWN, RX_HUNT, RX_DATA} rx_state_t;

   // ---------------------------------------------------------------- transmit
   logic        r_tx_busy;
   logic [4:0]  r_tx_idx;
   logic [63:0] r_tx_sh;
   logic [3:0]  r_txd;
   logic        w_tx_accept;

   assign tx_ready    = !r && (!r_tx_busy || r_tx_idx == 5'd16);
   assign w_tx_accept = tx_valid && tx_ready;
   assign txd         = r_txd;

   // Nibble 0 ({start, d65..d63}) goes straight out; the shifter holds the other 16.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge c or posedge r) begin
      if (r) begin
         r_tx_busy <= 1'b0;
         r_tx_idx  <= '0;
         r_tx_sh   <= '0;
         r_txd     <= TX_IDLE;
      end else if (w_tx_accept) begin
         r_tx_busy <= 1'b1;
         r_tx_idx  <= '0;
         r_txd     <= {1'b0, tx_data[65:63]} ^ TX_MASK;
         r_tx_sh   <= {tx_data[62:0], 1'b1};
      end else if (r_tx_busy) begin
         if (r_tx_idx == 5'd16) begin
            r_tx_busy <= 1'b0;
            r_txd     <= TX_IDLE;
         end else begin
            r_tx_idx <= r_tx_idx + 5'd1;
            r_txd    <= r_tx_sh[63:60] ^ TX_MASK;
            r_tx_sh  <= {r_tx_sh[59:0], 4'h0};
         end
      end
   end

   // ----------------------------------------------------------------- receive
   rx_state_t   r_state, w_state_nxt;
   logic [2:0]  r_idle_cnt, w_idle_nxt;
   logic [6:0]  r_bit_cnt, w_bit_nxt;
   logic [65:0] r_rx_sh, w_sh_nxt;
   logic [65:0] w_word;
   logic        w_word_done;
   logic [3:0]  w_rxd;
   logic        r_rx_valid;
   logic [65:0] r_rx_data;
   logic [15:0] r_rx_count;

   assign w_rxd    = rxd ^ {4{RINV}};
   assign link_up  = (r_state != RX_DOWN);
   assign rx_valid = r_rx_valid;
   assign rx_data  = r_rx_data;
   assign rx_count = r_rx_count;

   // NOTE: partial-word and shift registers are reset too, so a reset mid-frame leaves nothing stale.
   always_ff @(posedge c or posedge r) begin
      if (r) begin
         r_state    <= RX_DOWN;
         r_idle_cnt <= '0;
         r_bit_cnt  <= '0;
         r_rx_sh    <= '0;
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
         r_rx_count <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_idle_cnt <= w_idle_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_rx_sh    <= w_sh_nxt;
         r_rx_valid <= w_word_done;
         if (w_word_done) begin
            r_rx_data  <= w_word;
            r_rx_count <= r_rx_count + 16'd1;
         end
      end
   end

   // Bits are walked in line order (rxd[3] first); one frame may end and the next start in one nibble.
   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_idle_nxt  = r_idle_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_sh_nxt    = r_rx_sh;
      w_word      = r_rx_data;
      w_word_done = 1'b0;
      if (r_state == RX_DOWN) begin
         if (w_rxd == 4'hF) begin
            if (r_idle_cnt == 3'd7) begin
               w_state_nxt = RX_HUNT;
               w_idle_nxt  = '0;
            end else begin
               w_idle_nxt = r_idle_cnt + 3'd1;
            end
         end else begin
            w_idle_nxt = '0;
         end
      end else begin
         for (int i = 3; i >= 0; i--) begin
            if (w_state_nxt == RX_HUNT) begin
               if (!w_rxd[i]) begin
                  w_state_nxt = RX_DATA;
                  w_bit_nxt   = '0;
               end
            end else begin
               w_sh_nxt = {w_sh_nxt[64:0], w_rxd[i]};
               if (w_bit_nxt == 7'd65) begin
                  w_word      = w_sh_nxt;
                  w_word_done = 1'b1;
                  w_state_nxt = RX_HUNT;
               end else begin
                  w_bit_nxt = w_bit_nxt + 7'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lvds_host.sv
// Scoreboard bench for lvds_host: two instances (plain and fully inverted) share tx
// stimulus; a frame-level model predicts txd/tx_ready and loopback rx words.
module tb_lvds_host;

   logic        c = 1'b0;
   logic        r = 1'b1;
   logic        tx_valid = 1'b0;
   logic [65:0] tx_data = '0;
   logic [3:0]  rxd0 = 4'hF;
   logic [3:0]  rxd1 = 4'h0;

   logic        tx_ready0, tx_ready1, link_up0, link_up1, rx_valid0, rx_valid1;
   logic [3:0]  txd0, txd1;
   logic [65:0] rx_data0, rx_data1;
   logic [15:0] rx_count0, rx_count1;

   always #5 c = ~c;

   lvds_host #(.TINV(1'b0), .RINV(1'b0)) u_dut0 (
      .c(c), .r(r), .tx_valid(tx_valid), .tx_ready(tx_ready0), .tx_data(tx_data),
      .txd(txd0), .rxd(rxd0), .link_up(link_up0), .rx_valid(rx_valid0),
      .rx_data(rx_data0), .rx_count(rx_count0)
   );

   lvds_host #(.TINV(1'b1), .RINV(1'b1)) u_dut1 (
      .c(c), .r(r), .tx_valid(tx_valid), .tx_ready(tx_ready1), .tx_data(tx_data),
      .txd(txd1), .rxd(rxd1), .link_up(link_up1), .rx_valid(rx_valid1),
      .rx_data(rx_data1), .rx_count(rx_count1)
   );

   int          errors = 0;
   int          checks = 0;
   logic [3:0]  tx_exp[$];
   logic [65:0] rx_exp0[$];
   logic [65:0] rx_exp1[$];
   logic [15:0] cnt0 = '0;
   logic [15:0] cnt1 = '0;
   bit          loop_en = 1'b0;
   int          shift_sel = 0;
   int          restart_id = 0;

   task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [65:0] rand_word();
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  t;
      a = $urandom;
      b = $urandom;
      t = 2'($urandom_range(3, 0));
      return {t, a, b};
   endfunction

   // Reference model: a word becomes the 68-bit line frame {0, d, 1}, sent 4 bits per
   // cycle oldest first; the link accepts a new word only when nothing else is pending.
   task automatic monitor();
      logic [3:0]  nib;
      logic [67:0] f;
      logic        rdy;
      forever begin
         @(negedge c);
         if (r) begin
            tx_exp.delete();
            rx_exp0.delete();
            rx_exp1.delete();
            cnt0 = '0;
            cnt1 = '0;
            nib  = 4'hF;
         end else if (tx_exp.size() != 0) begin
            nib = tx_exp.pop_front();
         end else begin
            nib = 4'hF;
         end
         check("txd0", 66'(txd0), 66'(nib));
         check("txd1_inv", 66'(txd1), 66'(nib ^ 4'hF));
         rdy = !r && (tx_exp.size() == 0);
         check("tx_ready0", 66'(tx_ready0), 66'(rdy));
         check("tx_ready1", 66'(tx_ready1), 66'(rdy));
         if (rdy && tx_valid) begin
            f = {1'b0, tx_data, 1'b1};
            for (int n = 0; n < 17; n++) tx_exp.push_back(f[67 - 4 * n -: 4]);
            if (loop_en) begin
               rx_exp0.push_back(tx_data);
               rx_exp1.push_back(tx_data);
            end
         end
         if (rx_valid0) begin
            if (rx_exp0.size() == 0) begin
               check("rx_valid0_unexpected", 66'(rx_valid0), 66'(0));
            end else begin
               check("rx_data0", rx_data0, rx_exp0.pop_front());
               cnt0 = cnt0 + 16'd1;
               check("rx_count0", 66'(rx_count0), 66'(cnt0));
            end
         end
         if (rx_valid1) begin
            if (rx_exp1.size() == 0) begin
               check("rx_valid1_unexpected", 66'(rx_valid1), 66'(0));
            end else begin
               check("rx_data1", rx_data1, rx_exp1.pop_front());
               cnt1 = cnt1 + 16'd1;
               check("rx_count1", 66'(rx_count1), 66'(cnt1));
            end
         end
      end
   endtask

   // Loopback wire: each instance's own txd feeds its rxd through a bit FIFO that
   // starts with shift_sel line-idle bits, shifting the frame alignment.
   task automatic line_loop();
      bit q0[$];
      bit q1[$];
      int seen = 0;
      forever begin
         @(negedge c);
         if (loop_en) begin
            if (seen != restart_id) begin
               seen = restart_id;
               q0.delete();
               q1.delete();
               for (int i = 0; i < shift_sel; i++) begin
                  q0.push_back(1'b1);
                  q1.push_back(1'b0);
               end
            end
            for (int i = 3; i >= 0; i--) begin
               q0.push_back(txd0[i]);
               q1.push_back(txd1[i]);
            end
            for (int i = 3; i >= 0; i--) begin
               rxd0[i] = q0.pop_front();
               rxd1[i] = q1.pop_front();
            end
         end
      end
   endtask

   task automatic send_word(input logic [65:0] d);
      bit ok;
      ok       = 1'b0;
      tx_valid = 1'b1;
      tx_data  = d;
      for (int i = 0; i < 100; i++) begin
         @(negedge c);
         if (tx_ready0) begin
            ok = 1'b1;
            break;
         end
      end
      check("tx_accept_timeout", 66'(ok), 66'(1));
      @(posedge c);
      #1;
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge c);
         if (tx_exp.size() == 0 && rx_exp0.size() == 0 && rx_exp1.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_timeout", 66'(ok), 66'(1));
      repeat (4) @(posedge c);
      #1;
   endtask

   task automatic feed(input logic [3:0] n);
      rxd0 = n;
      rxd1 = n ^ 4'hF;
      @(posedge c);
      #1;
   endtask

   initial begin
      fork
         monitor();
         line_loop();
      join_none

      r = 1'b1;
      repeat (5) @(posedge c);
      #1;
      check("reset_link_up0", 66'(link_up0), 66'(0));
      check("reset_link_up1", 66'(link_up1), 66'(0));
      check("reset_rx_count0", 66'(rx_count0), 66'(0));
      check("reset_rx_data0", rx_data0, 66'(0));
      check("reset_rx_valid0", 66'(rx_valid0), 66'(0));
      r    = 1'b0;
      rxd0 = 4'h0;
      rxd1 = 4'hF;
      repeat (3) @(posedge c);
      #1;

      // Training: a single non-idle nibble restarts the count of eight.
      repeat (7) feed(4'hF);
      feed(4'h7);
      check("train_broken_link0", 66'(link_up0), 66'(0));
      repeat (7) feed(4'hF);
      check("train_7_link0", 66'(link_up0), 66'(0));
      check("train_7_link1", 66'(link_up1), 66'(0));
      feed(4'hF);
      check("train_8_link0", 66'(link_up0), 66'(1));
      check("train_8_link1", 66'(link_up1), 66'(1));

      // Loopback with 0..3 idle bits of alignment shift: single then back-to-back.
      loop_en = 1'b1;
      for (int s = 0; s < 4; s++) begin
         shift_sel = s;
         restart_id++;
         repeat (4) @(posedge c);
         #1;
         send_word((s == 0) ? 66'h3_0000_0000_0000_0001 : rand_word());
         wait_idle();
         send_word(rand_word());
         send_word(rand_word());
         wait_idle();
      end

      // Reset during tx nibble 8, with the rx side mid-frame.
      send_word(rand_word());
      repeat (8) @(posedge c);
      #1;
      r = 1'b1;
      #1;
      check("midreset_txd0", 66'(txd0), 66'(4'hF));
      check("midreset_txd1", 66'(txd1), 66'(4'h0));
      check("midreset_tx_ready0", 66'(tx_ready0), 66'(0));
      repeat (3) @(posedge c);
      #1;
      check("midreset_link_up0", 66'(link_up0), 66'(0));
      check("midreset_link_up1", 66'(link_up1), 66'(0));
      check("midreset_rx_count0", 66'(rx_count0), 66'(0));
      check("midreset_rx_data0", rx_data0, 66'(0));
      r = 1'b0;
      repeat (12) @(posedge c);
      #1;
      check("retrain_link_up0", 66'(link_up0), 66'(1));
      check("retrain_link_up1", 66'(link_up1), 66'(1));
      send_word(rand_word());
      send_word(rand_word());
      wait_idle();
      check("after_reset_rx_count0", 66'(rx_count0), 66'(2));
      check("after_reset_rx_count1", 66'(rx_count1), 66'(2));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lvds_host.md
# lvds_host

Host-end link engine for the LVDS remote-IO link: the counterpart of the target, running entirely in the 200 MHz word clock. It frames 66-bit words into a 4-bit-per-clock nibble stream for an external 4:1 serializer and deframes the nibble stream from an external oversampler/data-recovery stage into 66-bit words. Line format, matching the target: idle is all ones; a frame is one start bit (0), then d[65] down to d[0], MSB first.

## Interface
- TINV, 1'b0: invert all transmitted bits (txd XOR 4'hF).
- RINV, 1'b0: invert all received bits before deframing.

- c  input  1  word clock (200 MHz); all logic on posedge.
- r  input  1  reset, asynchronous, active-high.
- tx_valid  input  1  word offered for transmission.
- tx_ready  output  1  framer accepts tx_data this cycle.
- tx_data  input  66  word to send.
- txd  output  4  nibble to serializer; txd[3] goes on the line first. Registered.
- rxd  input  4  recovered nibble; rxd[3] arrived first.
- link_up  output  1  receiver trained (idle seen), deframing enabled.
- rx_valid  output  1  one-cycle pulse; rx_data holds a new word.
- rx_data  output  66  last received word; held until next rx_valid.
- rx_count  output  16  received-word counter, wraps 16'hFFFF -> 0.

## Operation
- Reset values: txd = 4'hF ^ {4{TINV}}, tx_ready = 0 while r high, link_up = 0, rx_valid = 0, rx_data = 0, rx_count = 0; rx FSM in DOWN, tx idle.
- TX: 67-bit frame {0, d[65:0]} plus one trailing 1 = 68 bits = 17 nibbles. Nibble n (0..16) carries frame bits 4n..4n+3; nibble 0 = {0,d65,d64,d63}, nibble 16 = {d2,d1,d0,1}.
- tx_ready = !r && (tx idle || txd currently holds nibble 16). Accept when tx_valid && tx_ready. Back-to-back accepts give continuous frames, 17-cycle cadence, no idle nibbles.
- TX idle: txd = all ones (before TINV).
- RX bits processed in time order (rxd[3] first) after XOR with {4{RINV}}. States:
  - DOWN: count consecutive rxd == 4'hF; any other nibble clears count. 8th consecutive -> HUNT, link_up = 1.
  - HUNT: first 0 bit is the start bit; following bits, including later bits of the same nibble, are data -> DATA.
  - DATA: collect 66 bits MSB first; on the 66th bit -> HUNT. Remaining bits of that nibble are scanned for a new start bit in the same cycle (at most one frame ends and one starts per nibble).
- Start bit may fall at any of 4 nibble positions; alignment is re-acquired per frame.
- rx_count increments with every rx_valid.
- Reset mid-frame: tx frame abandoned, txd forced idle immediately; partial rx word discarded, no rx_valid; rx returns to DOWN and must retrain.

## Timing
- Accept at edge k -> txd = nibble 0 from edge k through k+1, nibble 16 after edge k+16; ready high in that last cycle.
- Nibble containing d[0] sampled at edge k -> rx_valid high and rx_data updated in cycle after edge k (1-cycle latency); rx_count updates the same edge.
- link_up rises the cycle after the 8th consecutive idle nibble is sampled.
- rx_data stable except on rx_valid edges.

## Test plan
- Reset: hold r 5 cycles -> txd = 4'hF, tx_ready = 0, link_up = 0, rx_count = 0; after release tx_ready = 1.
- Single tx of 66'h3_0000_0000_0000_0001 -> txd sequence 6, 0 x15, 3 over 17 cycles, then 4'hF; with TINV = 1, sequence 9, F x15, C, then 0.
- Two back-to-back tx words -> 34 consecutive frame nibbles, tx_ready high on cycles 17 and 34, no idle between frames.
- Training: feed 7 x 4'hF, then 4'h7, then 7 x 4'hF -> link_up stays 0; one more 4'hF -> link_up = 1.
- Loopback txd -> rxd with 0, 1, 2, 3 idle bits prepended (bit shift): random words, single and back-to-back -> rx_data equals each sent word, rx_valid pulses once per word, rx_count = 2 after two frames.
- Assert r during tx nibble 8 and mid rx frame -> txd = 4'hF at once, no rx_valid, link_up = 0; after release, 8 idle nibbles plus a frame -> correct word received.
